// File: rtl/stage5_fence_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stage5_fence_pkg
// Description : Shared types and step-selection helper for the FENCE.I /
//               SFENCE.VMA sequencer of the five-stage pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package stage5_fence_pkg;

  // Sequencer states; the maintenance steps always run in declaration order.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DC_FLUSH  = 3'd1,
    IC_INV    = 3'd2,
    TLB_FLUSH = 3'd3,
    RELEASE   = 3'd4
  } fence_state_e;

  // Picks the state that follows cur, given the live fence levels.
  // The first enabled step strictly after cur wins (IDLE counts as "before
  // every step"). If no further step is enabled, a still-present fence goes
  // to RELEASE; a fence that has vanished (cancel) goes back to IDLE.
  function automatic fence_state_e next_step(
    input logic         ifence,
    input logic         sfence,
    input fence_state_e cur,
    input logic         dc_present,
    input logic         ic_present
  );
    logic         w_any;
    logic         w_en_dc;
    logic         w_en_ic;
    logic         w_en_tlb;
    fence_state_e w_nxt;
    w_any    = ifence | sfence;
    w_en_dc  = ifence & dc_present;
    w_en_ic  = ifence & ic_present;
    w_en_tlb = sfence;
    w_nxt    = w_any ? RELEASE : IDLE;
    case (cur)
      IDLE: begin
        if (w_en_dc)       w_nxt = DC_FLUSH;
        else if (w_en_ic)  w_nxt = IC_INV;
        else if (w_en_tlb) w_nxt = TLB_FLUSH;
      end
      DC_FLUSH: begin
        if (w_en_ic)       w_nxt = IC_INV;
        else if (w_en_tlb) w_nxt = TLB_FLUSH;
      end
      IC_INV: begin
        if (w_en_tlb)      w_nxt = TLB_FLUSH;
      end
      default: ;
    endcase
    return w_nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fence_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fence_req_ctrl
// Description : Generic level-request / pulse-done handshake. The request
//               rises the cycle after i_start and falls the cycle after an
//               accepted done; done pulses while no request is out are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module fence_req_ctrl (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_done,
  output logic o_req,
  output logic o_done_ok
);

  logic r_req;

  // Request register: once raised it is held until the responder completes,
  // so a request is never withdrawn mid-flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req <= 1'b0;
    end else if (r_req) begin
      if (i_done) r_req <= 1'b0;
    end else if (i_start) begin
      r_req <= 1'b1;
    end
  end

  assign o_req     = r_req;
  assign o_done_ok = r_req & i_done;

endmodule
`default_nettype wire

// File: rtl/stage5_fence_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : stage5_fence_sequencer
// Description : Runs the D$ flush, I$ invalidate and TLB flush handshakes
//               for FENCE.I / SFENCE.VMA and drives fence_stall to the
//               hazard unit, dropping it for the RELEASE cycle(s) so the
//               hazard unit can roll back and refetch.
// Revision    : 1.0 - initial release
// ============================================================================
module stage5_fence_sequencer
  import stage5_fence_pkg::*;
#(
  parameter int DCACHE_PRESENT = 1,
  parameter int ICACHE_PRESENT = 1,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_ifence,
  input  logic             i_sfence,
  output logic             o_dc_flush_req,
  input  logic             i_dc_flush_done,
  output logic             o_ic_inv_req,
  input  logic             i_ic_inv_done,
  output logic             o_tlb_flush_req,
  input  logic             i_tlb_flush_done,
  output logic             o_fence_stall,
  output logic [CNT_W-1:0] o_fence_cycles
);

  localparam logic C_DC_EN = (DCACHE_PRESENT != 0);
  localparam logic C_IC_EN = (ICACHE_PRESENT != 0);

  fence_state_e     r_state;
  fence_state_e     w_state_nxt;
  logic             w_stall;
  logic             w_any_fence;
  logic             w_dc_req;
  logic             w_ic_req;
  logic             w_tlb_req;
  logic             w_dc_ok;
  logic             w_ic_ok;
  logic             w_tlb_ok;
  logic             w_dc_start;
  logic             w_ic_start;
  logic             w_tlb_start;
  logic [CNT_W-1:0] r_cycles;

  assign w_any_fence = i_ifence | i_sfence;

  // A step's request is launched on the first cycle spent in that state.
  assign w_dc_start  = (r_state == DC_FLUSH)  & ~w_dc_req;
  assign w_ic_start  = (r_state == IC_INV)    & ~w_ic_req;
  assign w_tlb_start = (r_state == TLB_FLUSH) & ~w_tlb_req;

  fence_req_ctrl u_dc_ctrl (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_dc_start),
    .i_done    (i_dc_flush_done),
    .o_req     (w_dc_req),
    .o_done_ok (w_dc_ok)
  );

  fence_req_ctrl u_ic_ctrl (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_ic_start),
    .i_done    (i_ic_inv_done),
    .o_req     (w_ic_req),
    .o_done_ok (w_ic_ok)
  );

  fence_req_ctrl u_tlb_ctrl (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_tlb_start),
    .i_done    (i_tlb_flush_done),
    .o_req     (w_tlb_req),
    .o_done_ok (w_tlb_ok)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and stall decode. Stall rises combinationally in IDLE so
  // the hazard unit never sees a bubble in which rollback could fire early.
  // A step only advances on an accepted done, so a cancelled fence still
  // completes the handshake already in flight before returning to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any_fence) begin
          w_stall     = 1'b1;
          w_state_nxt = next_step(i_ifence, i_sfence, IDLE, C_DC_EN, C_IC_EN);
        end
      end
      DC_FLUSH: begin
        w_stall = 1'b1;
        if (w_dc_ok)
          w_state_nxt = next_step(i_ifence, i_sfence, DC_FLUSH, C_DC_EN, C_IC_EN);
      end
      IC_INV: begin
        w_stall = 1'b1;
        if (w_ic_ok)
          w_state_nxt = next_step(i_ifence, i_sfence, IC_INV, C_DC_EN, C_IC_EN);
      end
      TLB_FLUSH: begin
        w_stall = 1'b1;
        if (w_tlb_ok)
          w_state_nxt = next_step(i_ifence, i_sfence, TLB_FLUSH, C_DC_EN, C_IC_EN);
      end
      RELEASE: begin
        // Wait for the fence instruction to leave M so a held instruction
        // (halt or dmem stall) cannot trigger a second sequence.
        if (!w_any_fence) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Saturating count of stalled cycles; sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycles <= '0;
    end else if (w_stall && (r_cycles != {CNT_W{1'b1}})) begin
      r_cycles <= r_cycles + CNT_W'(1);
    end
  end

  // Requests come from the step registers, which are mutually exclusive
  // because only the current state can launch one.
  a_req_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0({w_dc_req, w_ic_req, w_tlb_req}));

  assign o_dc_flush_req  = w_dc_req;
  assign o_ic_inv_req    = w_ic_req;
  assign o_tlb_flush_req = w_tlb_req;
  // The IDLE decode looks at the raw fence inputs, so keep stall quiet
  // while reset is held.
  assign o_fence_stall   = w_stall & ~rst;
  assign o_fence_cycles  = r_cycles;

endmodule
`default_nettype wire

// File: tb/tb_stage5_fence_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_stage5_fence_sequencer
// Description : Self-checking bench. Three DUTs: 0 = both caches present,
//               1 = no caches, 2 = both caches with a 3-bit counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stage5_fence_sequencer;

  typedef struct {
    logic [4:0]  in;     // {ifence, sfence, dc_done, ic_done, tlb_done}
    logic [2:0]  req;    // {dc_req, ic_req, tlb_req}
    logic        stall;
    logic [15:0] cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  ifn, sfn, dcd, icd, tld;
  logic [2:0]  dcr, icr, tlr, stl;
  logic [15:0] cnt0, cnt1;
  logic [2:0]  cnt2;

  int   n_vec = 0;
  int   n_err = 0;
  vec_t exp_q[$];
  vec_t tbl_a[33];
  vec_t tbl_b[9];

  always #5 clk = ~clk;

  stage5_fence_sequencer #(.DCACHE_PRESENT(1), .ICACHE_PRESENT(1), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst(rst), .i_ifence(ifn[0]), .i_sfence(sfn[0]),
    .o_dc_flush_req(dcr[0]), .i_dc_flush_done(dcd[0]),
    .o_ic_inv_req(icr[0]), .i_ic_inv_done(icd[0]),
    .o_tlb_flush_req(tlr[0]), .i_tlb_flush_done(tld[0]),
    .o_fence_stall(stl[0]), .o_fence_cycles(cnt0));

  stage5_fence_sequencer #(.DCACHE_PRESENT(0), .ICACHE_PRESENT(0), .CNT_W(16)) u_dut_b (
    .clk(clk), .rst(rst), .i_ifence(ifn[1]), .i_sfence(sfn[1]),
    .o_dc_flush_req(dcr[1]), .i_dc_flush_done(dcd[1]),
    .o_ic_inv_req(icr[1]), .i_ic_inv_done(icd[1]),
    .o_tlb_flush_req(tlr[1]), .i_tlb_flush_done(tld[1]),
    .o_fence_stall(stl[1]), .o_fence_cycles(cnt1));

  stage5_fence_sequencer #(.DCACHE_PRESENT(1), .ICACHE_PRESENT(1), .CNT_W(3)) u_dut_c (
    .clk(clk), .rst(rst), .i_ifence(ifn[2]), .i_sfence(sfn[2]),
    .o_dc_flush_req(dcr[2]), .i_dc_flush_done(dcd[2]),
    .o_ic_inv_req(icr[2]), .i_ic_inv_done(icd[2]),
    .o_tlb_flush_req(tlr[2]), .i_tlb_flush_done(tld[2]),
    .o_fence_stall(stl[2]), .o_fence_cycles(cnt2));

  function automatic vec_t mk(logic [4:0] in, logic [2:0] req, logic stall, logic [15:0] cnt);
    vec_t v;
    v.in = in; v.req = req; v.stall = stall; v.cnt = cnt;
    return v;
  endfunction

  function automatic logic [15:0] get_cnt(int s);
    if (s == 0) return cnt0;
    if (s == 1) return cnt1;
    return {13'd0, cnt2};
  endfunction

  task automatic drive(int s, logic [4:0] in);
    ifn[s] = in[4]; sfn[s] = in[3]; dcd[s] = in[2]; icd[s] = in[1]; tld[s] = in[0];
  endtask

  // Pops the oldest expectation and compares the selected DUT's outputs.
  task automatic check_out(int s, string tag, int row);
    vec_t e;
    logic [2:0] r;
    e = exp_q.pop_front();
    r = {dcr[s], icr[s], tlr[s]};
    n_vec++;
    if (r !== e.req) begin
      n_err++;
      $display("FAIL %s req dut=%0d row=%0d got=%b want=%b", tag, s, row, r, e.req);
    end
    n_vec++;
    if (stl[s] !== e.stall) begin
      n_err++;
      $display("FAIL %s stall dut=%0d row=%0d got=%b want=%b", tag, s, row, stl[s], e.stall);
    end
    n_vec++;
    if (get_cnt(s) !== e.cnt) begin
      n_err++;
      $display("FAIL %s cycles dut=%0d row=%0d got=%0d want=%0d", tag, s, row, get_cnt(s), e.cnt);
    end
  endtask

  task automatic apply(int s, vec_t v, string tag, int row);
    @(negedge clk);
    drive(s, v.in);
    exp_q.push_back(v);
    #4;
    check_out(s, tag, row);
  endtask

  // Runs one FENCE.I on DUT s with done returned in the first req cycle;
  // returns the number of stalled cycles observed (bounded).
  task automatic run_auto(int s, output int stalls);
    bit fin;
    stalls = 0;
    fin = 1'b0;
    for (int k = 0; k < 30 && !fin; k++) begin
      @(negedge clk);
      ifn[s] = 1'b1;
      dcd[s] = dcr[s]; icd[s] = icr[s]; tld[s] = tlr[s];
      #4;
      if (!stl[s]) fin = 1'b1;
      else stalls++;
    end
    if (!fin) begin
      n_vec++; n_err++;
      $display("FAIL auto_timeout dut=%0d got=stall_stuck want=release", s);
    end
    @(negedge clk);
    ifn[s] = 1'b0; dcd[s] = 1'b0; icd[s] = 1'b0; tld[s] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    // FENCE.I, done two cycles after each req, held in RELEASE, re-fence
    // then cancel during DC_FLUSH, stray dones in IDLE, then ifence+sfence
    // with done in the first req cycle (7-cycle minimum).
    tbl_a[0]  = mk(5'b10000, 3'b000, 1, 0);
    tbl_a[1]  = mk(5'b10000, 3'b000, 1, 1);
    tbl_a[2]  = mk(5'b10000, 3'b100, 1, 2);
    tbl_a[3]  = mk(5'b10000, 3'b100, 1, 3);
    tbl_a[4]  = mk(5'b10100, 3'b100, 1, 4);
    tbl_a[5]  = mk(5'b10000, 3'b000, 1, 5);
    tbl_a[6]  = mk(5'b10000, 3'b010, 1, 6);
    tbl_a[7]  = mk(5'b10000, 3'b010, 1, 7);
    tbl_a[8]  = mk(5'b10010, 3'b010, 1, 8);
    tbl_a[9]  = mk(5'b10000, 3'b000, 0, 9);
    tbl_a[10] = mk(5'b10000, 3'b000, 0, 9);
    tbl_a[11] = mk(5'b10000, 3'b000, 0, 9);
    tbl_a[12] = mk(5'b10000, 3'b000, 0, 9);
    tbl_a[13] = mk(5'b00000, 3'b000, 0, 9);
    tbl_a[14] = mk(5'b00000, 3'b000, 0, 9);
    tbl_a[15] = mk(5'b10000, 3'b000, 1, 9);
    tbl_a[16] = mk(5'b10000, 3'b000, 1, 10);
    tbl_a[17] = mk(5'b00000, 3'b100, 1, 11);
    tbl_a[18] = mk(5'b00000, 3'b100, 1, 12);
    tbl_a[19] = mk(5'b00100, 3'b100, 1, 13);
    tbl_a[20] = mk(5'b00010, 3'b000, 0, 14);
    tbl_a[21] = mk(5'b00101, 3'b000, 0, 14);
    tbl_a[22] = mk(5'b00000, 3'b000, 0, 14);
    tbl_a[23] = mk(5'b11000, 3'b000, 1, 14);
    tbl_a[24] = mk(5'b11000, 3'b000, 1, 15);
    tbl_a[25] = mk(5'b11100, 3'b100, 1, 16);
    tbl_a[26] = mk(5'b11000, 3'b000, 1, 17);
    tbl_a[27] = mk(5'b11011, 3'b010, 1, 18);
    tbl_a[28] = mk(5'b11000, 3'b000, 1, 19);
    tbl_a[29] = mk(5'b11001, 3'b001, 1, 20);
    tbl_a[30] = mk(5'b11000, 3'b000, 0, 21);
    tbl_a[31] = mk(5'b00000, 3'b000, 0, 21);
    tbl_a[32] = mk(5'b00000, 3'b000, 0, 21);
    // No caches: sfence runs only the TLB step; ifence alone stalls one cycle.
    tbl_b[0] = mk(5'b01000, 3'b000, 1, 0);
    tbl_b[1] = mk(5'b01100, 3'b000, 1, 1);
    tbl_b[2] = mk(5'b01001, 3'b001, 1, 2);
    tbl_b[3] = mk(5'b01000, 3'b000, 0, 3);
    tbl_b[4] = mk(5'b00000, 3'b000, 0, 3);
    tbl_b[5] = mk(5'b10000, 3'b000, 1, 3);
    tbl_b[6] = mk(5'b10000, 3'b000, 0, 4);
    tbl_b[7] = mk(5'b00000, 3'b000, 0, 4);
    tbl_b[8] = mk(5'b00000, 3'b000, 0, 4);

    // Reset held three cycles with ifence high.
    rst = 1'b1;
    ifn = 3'b111; sfn = 3'b000; dcd = 3'b000; icd = 3'b000; tld = 3'b000;
    repeat (3) @(negedge clk);
    #4;
    for (int s = 0; s < 3; s++) begin
      exp_q.push_back(mk(5'b10000, 3'b000, 0, 0));
      check_out(s, "reset", 0);
    end
    @(negedge clk);
    rst = 1'b0;
    ifn = 3'b000;

    for (int i = 0; i < 33; i++) apply(0, tbl_a[i], "seq_a", i);
    for (int i = 0; i < 9; i++)  apply(1, tbl_b[i], "seq_b", i);

    // Saturation on the 3-bit counter: 5 stall cycles per fence.
    run_auto(2, st);
    n_vec++;
    if (st != 5) begin n_err++; $display("FAIL sat_stalls got=%0d want=5", st); end
    n_vec++;
    if (cnt2 !== 3'd5) begin n_err++; $display("FAIL sat_run1 got=%0d want=5", cnt2); end
    run_auto(2, st);
    n_vec++;
    if (cnt2 !== 3'd7) begin n_err++; $display("FAIL sat_run2 got=%0d want=7", cnt2); end
    run_auto(2, st);
    n_vec++;
    if (cnt2 !== 3'd7) begin n_err++; $display("FAIL sat_run3 got=%0d want=7", cnt2); end

    // Reset while a D$ request is outstanding abandons the sequence.
    apply(0, mk(5'b10000, 3'b000, 1, 21), "mid_rst", 0);
    apply(0, mk(5'b10000, 3'b000, 1, 22), "mid_rst", 1);
    apply(0, mk(5'b10000, 3'b100, 1, 23), "mid_rst", 2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #4;
    exp_q.push_back(mk(5'b10000, 3'b000, 0, 0));
    check_out(0, "mid_rst", 3);
    @(negedge clk);
    rst = 1'b0;
    ifn[0] = 1'b0;
    #4;
    exp_q.push_back(mk(5'b00000, 3'b000, 0, 0));
    check_out(0, "mid_rst", 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
